// File: rtl/piano_roll_pkg.sv
// Shared constants for the piano-roll pixel pipeline and any overlay stages placed after it.
package piano_roll_pkg;

  localparam logic [23:0] COL_NOTE = 24'hFFA000;
  localparam logic [23:0] COL_GRID = 24'h202020;
  localparam logic [23:0] COL_BG   = 24'h000000;

  localparam int unsigned PIPE_LATENCY = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } sync_t;

endpackage

// File: rtl/note_col_ram.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM friendly).
module note_col_ram #(
  parameter int unsigned Depth = 160,
  parameter int unsigned Width = 48,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/piano_roll_renderer.sv
// Scrolling piano-roll renderer: note columns stream into a ring buffer, pixels read it back
// through a two-stage pipeline with sync signals delayed to match.
module piano_roll_renderer
  import piano_roll_pkg::*;
#(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned NUM_NOTES       = 48,
  parameter int unsigned ROW_H           = 15,
  parameter int unsigned COL_W           = 8,
  parameter int unsigned HIST_COLS       = 160
) (
  input  logic                 clk_pixel_in,
  input  logic                 rst_in,
  input  logic [10:0]          hcount_in,
  input  logic [9:0]           vcount_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 ad_in,
  input  logic                 nf_in,
  input  logic                 note_valid_in,
  output logic                 note_ready_out,
  input  logic [NUM_NOTES-1:0] note_mask_in,
  output logic [23:0]          rgb_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 ad_out
);

  localparam int unsigned CW = (HIST_COLS > 1) ? $clog2(HIST_COLS) : 1;
  localparam int unsigned FW = $clog2(HIST_COLS + 1);
  localparam int unsigned PW = (COL_W > 1) ? $clog2(COL_W) : 1;
  localparam int unsigned RW = (ROW_H > 1) ? $clog2(ROW_H) : 1;
  localparam int unsigned NW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  localparam logic [10:0]   H_LAST   = 11'(ACTIVE_H_PIXELS - 1);
  localparam logic [9:0]    V_ACT    = 10'(ACTIVE_LINES);
  localparam logic [PW-1:0] PX_LAST  = PW'(COL_W - 1);
  localparam logic [RW-1:0] RL_LAST  = RW'(ROW_H - 1);
  localparam logic [CW-1:0] PTR_LAST = CW'(HIST_COLS - 1);
  localparam logic [CW:0]   HIST_A   = (CW + 1)'(HIST_COLS);
  localparam logic [FW-1:0] HIST_F   = FW'(HIST_COLS);
  localparam logic [NW-1:0] TOP_NOTE = NW'(NUM_NOTES - 1);

  logic                 ready_q;
  logic                 xfer;
  logic [CW-1:0]        wr_ptr_q, disp_base_q;
  logic [FW-1:0]        filled_q, disp_filled_q;

  logic [PW-1:0]        col_px_q, col_px, col_px_d;
  logic [CW-1:0]        col_idx_q, col_idx, col_idx_d;
  logic [RW-1:0]        row_line_q, row_line;
  logic [NW-1:0]        row_idx_q, row_idx;

  logic [CW:0]          addr_sum;
  logic [CW-1:0]        rd_addr;
  logic [NUM_NOTES-1:0] rd_data;

  logic [NW-1:0]        note_row_q;
  logic                 grid_q, unwr_q;
  sync_t                s1_q, s2_q;
  logic [23:0]          rgb_q, rgb_d;

  assign note_ready_out = ready_q;
  assign xfer           = note_valid_in & ready_q;

  // Column ring buffer; the display snapshot only moves on nf_in so a frame never tears.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      ready_q       <= 1'b0;
      wr_ptr_q      <= '0;
      filled_q      <= '0;
      disp_base_q   <= '0;
      disp_filled_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if (xfer) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (filled_q != HIST_F) begin
          filled_q <= filled_q + 1'b1;
        end
      end
      if (nf_in) begin
        disp_base_q   <= wr_ptr_q;
        disp_filled_q <= filled_q;
      end
    end
  end

  // Current-pixel position from counters; registers hold the prediction for the next cycle.
  always_comb begin
    col_px  = col_px_q;
    col_idx = col_idx_q;
    if (hcount_in == '0) begin
      col_px  = '0;
      col_idx = '0;
    end
    col_px_d  = col_px;
    col_idx_d = col_idx;
    if (hcount_in < H_LAST) begin
      if (col_px == PX_LAST) begin
        col_px_d  = '0;
        col_idx_d = col_idx + 1'b1;
      end else begin
        col_px_d = col_px + 1'b1;
      end
    end

    row_line = row_line_q;
    row_idx  = row_idx_q;
    if (hcount_in == '0) begin
      if (vcount_in == '0) begin
        row_line = '0;
        row_idx  = '0;
      end else if (vcount_in < V_ACT) begin
        if (row_line_q == RL_LAST) begin
          row_line = '0;
          row_idx  = row_idx_q + 1'b1;
        end else begin
          row_line = row_line_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      col_px_q   <= '0;
      col_idx_q  <= '0;
      row_line_q <= '0;
      row_idx_q  <= '0;
    end else begin
      col_px_q   <= col_px_d;
      col_idx_q  <= col_idx_d;
      row_line_q <= row_line;
      row_idx_q  <= row_idx;
    end
  end

  always_comb begin
    addr_sum = {1'b0, disp_base_q} + {1'b0, col_idx};
    rd_addr  = addr_sum[CW-1:0];
    if (addr_sum >= HIST_A) begin
      rd_addr = CW'(addr_sum - HIST_A);
    end
  end

  note_col_ram #(
    .Depth (HIST_COLS),
    .Width (NUM_NOTES)
  ) u_ram (
    .clk     (clk_pixel_in),
    .we      (xfer),
    .wr_addr (wr_ptr_q),
    .wr_data (note_mask_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    rgb_d = COL_BG;
    if (!s1_q.ad) begin
      rgb_d = COL_BG;
    end else if (rd_data[note_row_q] && !unwr_q) begin
      rgb_d = COL_NOTE;
    end else if (grid_q) begin
      rgb_d = COL_GRID;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      s1_q       <= '0;
      s2_q       <= '0;
      rgb_q      <= '0;
      note_row_q <= '0;
      grid_q     <= 1'b0;
      unwr_q     <= 1'b0;
    end else begin
      s1_q.hs    <= hs_in;
      s1_q.vs    <= vs_in;
      s1_q.ad    <= ad_in;
      note_row_q <= TOP_NOTE - row_idx;
      grid_q     <= (row_line == '0);
      unwr_q     <= (FW'(col_idx) < (HIST_F - disp_filled_q));
      s2_q       <= s1_q;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;
  assign hs_out  = s2_q.hs;
  assign vs_out  = s2_q.vs;
  assign ad_out  = s2_q.ad;

endmodule

// File: tb/tb_piano_roll_renderer.sv
// Scaled-down piano-roll bench: per-pixel scoreboard from a reference model plus spot-pixel tables.
module tb_piano_roll_renderer;

  localparam int HA  = 64;
  localparam int VA  = 24;
  localparam int NN  = 8;
  localparam int RH  = 3;
  localparam int CWD = 4;
  localparam int HC  = 16;
  localparam int HT  = 72;
  localparam int VT  = 27;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [10:0]   hcount_in = '0;
  logic [9:0]    vcount_in = '0;
  logic          hs_in = 1'b0, vs_in = 1'b0, ad_in = 1'b0, nf_in = 1'b0;
  logic          note_valid_in = 1'b0;
  logic          note_ready_out;
  logic [NN-1:0] note_mask_in = '0;
  logic [23:0]   rgb_out;
  logic          hs_out, vs_out, ad_out;

  piano_roll_renderer #(
    .ACTIVE_H_PIXELS (HA),
    .ACTIVE_LINES    (VA),
    .NUM_NOTES       (NN),
    .ROW_H           (RH),
    .COL_W           (CWD),
    .HIST_COLS       (HC)
  ) dut (
    .clk_pixel_in   (clk),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hs_in          (hs_in),
    .vs_in          (vs_in),
    .ad_in          (ad_in),
    .nf_in          (nf_in),
    .note_valid_in  (note_valid_in),
    .note_ready_out (note_ready_out),
    .note_mask_in   (note_mask_in),
    .rgb_out        (rgb_out),
    .hs_out         (hs_out),
    .vs_out         (vs_out),
    .ad_out         (ad_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        ad;
    bit          care;
    bit          cap;
    int          h;
    int          v;
  } exp_t;

  typedef struct {
    int          frame;
    int          h;
    int          v;
    logic [23:0] rgb;
  } spot_t;

  exp_t          sb[$];
  spot_t         spots[$];
  logic [NN-1:0] pend[$];
  logic [NN-1:0] nf_mask[$];
  logic [23:0]   cap [VA][HA];

  int n_chk  = 0;
  int n_fail = 0;

  logic [NN-1:0] m_mem [HC];
  int m_wr = 0, m_filled = 0, m_base = 0, m_dfill = 0;
  bit m_ready = 0, m_resync = 1, m_known = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int h, input int v);
    int col, note, a;
    if (h >= HA || v >= VA) return 24'h000000;
    col  = h / CWD;
    note = NN - 1 - v / RH;
    a    = (m_base + col) % HC;
    if (col >= HC - m_dfill && m_mem[a][note] === 1'b1) return 24'hFFA000;
    if (v % RH == 0) return 24'h202020;
    return 24'h000000;
  endfunction

  task automatic tick(input int h, input int v, input bit rst, input bit valid,
                      input logic [NN-1:0] mask);
    exp_t e;
    bit   hs, vs, ad, nf;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.care) check($sformatf("rgb(%0d,%0d)", e.h, e.v), 32'(rgb_out), 32'(e.rgb));
      check($sformatf("sync(%0d,%0d)", e.h, e.v), 32'({hs_out, vs_out, ad_out}),
            32'({e.hs, e.vs, e.ad}));
      if (e.cap) cap[e.v][e.h] = rgb_out;
    end
    if (m_known) check($sformatf("ready(%0d,%0d)", h, v), 32'(note_ready_out), 32'(m_ready));

    hs = (h >= 66 && h < 70);
    vs = (v == 25);
    ad = (h < HA && v < VA);
    nf = (h == HT - 1 && v == VT - 1);
    rst_in        = rst;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    hs_in         = hs;
    vs_in         = vs;
    ad_in         = ad;
    nf_in         = nf;
    note_valid_in = valid;
    note_mask_in  = mask;

    if (rst) begin
      foreach (sb[i]) begin
        sb[i].rgb = '0; sb[i].hs = 0; sb[i].vs = 0; sb[i].ad = 0;
        sb[i].care = 1; sb[i].cap = 0;
      end
      e = '{rgb: '0, hs: 0, vs: 0, ad: 0, care: 1, cap: 0, h: h, v: v};
      sb.push_back(e);
      m_ready = 0; m_wr = 0; m_filled = 0; m_base = 0; m_dfill = 0;
      m_resync = 1; m_known = 1;
    end else begin
      if (h == 0 && v == 0) m_resync = 0;
      e = '{rgb: exp_pix(h, v), hs: hs, vs: vs, ad: ad, care: !m_resync, cap: ad && !m_resync,
            h: h, v: v};
      sb.push_back(e);
      if (nf) begin
        m_base  = m_wr;
        m_dfill = m_filled;
      end
      if (valid && m_ready) begin
        m_mem[m_wr] = mask;
        m_wr = (m_wr + 1) % HC;
        if (m_filled < HC) m_filled++;
      end
      m_ready = 1;
    end
  endtask

  task automatic run_frame(input int fidx, input int rst_h, input int rst_v);
    bit            rst, valid;
    logic [NN-1:0] mask;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        rst   = (h == rst_h && v == rst_v);
        valid = 0;
        mask  = '0;
        if (!rst && h == HT - 1 && v == VT - 1) begin
          if (nf_mask.size() > 0) begin
            valid = 1;
            mask  = nf_mask.pop_front();
          end
        end else if (!rst && v >= VA && m_ready && pend.size() > 0) begin
          valid = 1;
          mask  = pend.pop_front();
        end
        tick(h, v, rst, valid, mask);
      end
    end
    foreach (spots[i]) begin
      if (spots[i].frame == fidx) begin
        check($sformatf("spot f%0d (%0d,%0d)", fidx, spots[i].h, spots[i].v),
              32'(cap[spots[i].v][spots[i].h]), 32'(spots[i].rgb));
      end
    end
  endtask

  initial begin
    // Frame 0: empty roll; 1: single column bit 0; 2: wrap after 17 columns;
    // 3/4: column written on the nf cycle absent then present; 6: after mid-frame reset;
    // 7: after 200 back-to-back writes.
    spots.push_back('{0, 0, 0, 24'h202020});
    spots.push_back('{0, 5, 1, 24'h000000});
    spots.push_back('{0, 63, 21, 24'h202020});
    spots.push_back('{1, 60, 21, 24'hFFA000});
    spots.push_back('{1, 63, 23, 24'hFFA000});
    spots.push_back('{1, 59, 21, 24'h202020});
    spots.push_back('{1, 59, 22, 24'h000000});
    spots.push_back('{1, 60, 20, 24'h000000});
    spots.push_back('{2, 0, 18, 24'hFFA000});
    spots.push_back('{2, 3, 20, 24'hFFA000});
    spots.push_back('{2, 0, 21, 24'h202020});
    spots.push_back('{2, 63, 21, 24'hFFA000});
    spots.push_back('{2, 4, 16, 24'hFFA000});
    spots.push_back('{2, 56, 1, 24'hFFA000});
    spots.push_back('{2, 52, 1, 24'h000000});
    spots.push_back('{3, 63, 1, 24'h000000});
    spots.push_back('{3, 63, 21, 24'hFFA000});
    spots.push_back('{4, 63, 1, 24'hFFA000});
    spots.push_back('{4, 63, 4, 24'hFFA000});
    spots.push_back('{4, 59, 21, 24'hFFA000});
    spots.push_back('{4, 0, 15, 24'hFFA000});
    spots.push_back('{6, 63, 21, 24'h202020});
    spots.push_back('{6, 63, 1, 24'h000000});
    spots.push_back('{6, 0, 15, 24'h202020});
    spots.push_back('{7, 0, 0, 24'hFFA000});
    spots.push_back('{7, 0, 9, 24'hFFA000});
    spots.push_back('{7, 0, 18, 24'h202020});
    spots.push_back('{7, 63, 21, 24'hFFA000});
    spots.push_back('{7, 63, 3, 24'hFFA000});
    spots.push_back('{7, 63, 7, 24'h000000});

    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, '0);

    pend.push_back(NN'(1));
    run_frame(0, -1, -1);

    for (int k = 1; k <= 16; k++) pend.push_back(NN'(1 << (k % NN)));
    run_frame(1, -1, -1);

    nf_mask.push_back(NN'(8'hFF));
    run_frame(2, -1, -1);
    run_frame(3, -1, -1);
    run_frame(4, -1, -1);

    run_frame(5, 30, 12);

    for (int i = 0; i < 200; i++) pend.push_back(NN'(i));
    run_frame(6, -1, -1);
    run_frame(7, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
